// File: rtl/sdram_page_arbiter.sv
// Page-granular arbiter between the image write path and the host read path
// of a frame buffer held in SDRAM; issues one page command at a time.
module sdram_page_arbiter #(
  parameter int PAGE_WORDS  = 512,
  parameter int FIFO_DEPTH  = 2048,
  parameter int FRAME_PAGES = 600
) (
  input  logic        sdram_clk,
  input  logic        reset,
  input  logic        wr_enable,
  input  logic        rd_enable,
  input  logic [10:0] wr_fifo_count,
  input  logic [10:0] rd_fifo_count,
  input  logic [14:0] wr_start_row,
  input  logic [14:0] rd_start_row,
  input  logic        frame_done,
  input  logic        rd_restart,
  input  logic        cmd_ack,
  input  logic        cmd_done,
  output logic        cmd_pagewrite,
  output logic        cmd_pageread,
  output logic [14:0] rowaddr,
  output logic        busy,
  output logic [9:0]  wr_page_cnt,
  output logic [9:0]  rd_page_cnt
);

  typedef enum logic [1:0] {IDLE, WACK, RACK, BUSY} state_t;

  state_t state;
  logic   last_rd;
  logic   wr_pend, rd_pend;
  logic   wr_elig, rd_elig, grant_wr;

  assign wr_elig  = wr_enable && (int'(wr_fifo_count) >= PAGE_WORDS) &&
                    (int'(wr_page_cnt) < FRAME_PAGES);
  // Reads may only trail pages already written this frame.
  assign rd_elig  = rd_enable && ((FIFO_DEPTH - int'(rd_fifo_count)) >= PAGE_WORDS) &&
                    (rd_page_cnt < wr_page_cnt);
  assign grant_wr = wr_elig && (!rd_elig || last_rd);

  always_ff @(posedge sdram_clk) begin
    if (reset) begin
      state         <= IDLE;
      cmd_pagewrite <= 1'b0;
      cmd_pageread  <= 1'b0;
      rowaddr       <= '0;
      busy          <= 1'b0;
      wr_page_cnt   <= '0;
      rd_page_cnt   <= '0;
      wr_pend       <= 1'b0;
      rd_pend       <= 1'b0;
      last_rd       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (frame_done) wr_page_cnt <= '0;
          if (rd_restart) rd_page_cnt <= '0;
          if (grant_wr) begin
            state         <= WACK;
            cmd_pagewrite <= 1'b1;
            busy          <= 1'b1;
            rowaddr       <= wr_start_row + 15'(wr_page_cnt);
            last_rd       <= 1'b0;
          end else if (rd_elig) begin
            state        <= RACK;
            cmd_pageread <= 1'b1;
            busy         <= 1'b1;
            rowaddr      <= rd_start_row + 15'(rd_page_cnt);
            last_rd      <= 1'b1;
          end
        end
        WACK: begin
          if (frame_done) wr_pend <= 1'b1;
          if (rd_restart) rd_pend <= 1'b1;
          if (cmd_ack) begin
            state         <= BUSY;
            cmd_pagewrite <= 1'b0;
            if (int'(wr_page_cnt) < FRAME_PAGES) wr_page_cnt <= wr_page_cnt + 10'd1;
          end
        end
        RACK: begin
          if (frame_done) wr_pend <= 1'b1;
          if (rd_restart) rd_pend <= 1'b1;
          if (cmd_ack) begin
            state        <= BUSY;
            cmd_pageread <= 1'b0;
            if (int'(rd_page_cnt) < FRAME_PAGES) rd_page_cnt <= rd_page_cnt + 10'd1;
          end
        end
        BUSY: begin
          if (cmd_done) begin
            // Deferred restarts land as we re-enter IDLE, including one arriving now.
            state   <= IDLE;
            busy    <= 1'b0;
            wr_pend <= 1'b0;
            rd_pend <= 1'b0;
            if (wr_pend || frame_done) wr_page_cnt <= '0;
            if (rd_pend || rd_restart) rd_page_cnt <= '0;
          end else begin
            if (frame_done) wr_pend <= 1'b1;
            if (rd_restart) rd_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
